pc_gen: RTL and testbench

//  Parametrised fetch PC generator for the DLX pipeline; successor of the fixed 32-bit +4 PC register.

---
 rtl/pc_gen_if.sv | 22 ++
 rtl/pc_gen.sv | 180 ++++++++++++++++++
 tb/tb_pc_gen.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if -- fetch handshake bus between the PC generator and the IF stage.
//
// Signals:
//   pc_out    current fetch PC (driven by the generator)
//   pc_valid  pc_out is valid for fetch (driven by the generator)
//   pc_seq    pc_out + INCR, modulo 2^XLEN (driven by the generator)
//   pc_ready  IF stage accepts pc_out this cycle (driven by the IF stage)
//
// Modports: master = PC generator side, slave = IF stage side.
// ---------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc_seq;
    logic            pc_valid;
    logic            pc_ready;

    modport master (output pc_out, output pc_valid, output pc_seq, input pc_ready);
    modport slave  (input pc_out, input pc_valid, input pc_seq, output pc_ready);
endinterface

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- parametrised fetch PC generator for the DLX pipeline.
//
// Presents the fetch PC to the IF stage over a valid/ready handshake and
// advances it by INCR on every accepted PC. Trap, redirect and RAS return
// events load a new (aligned) target and insert one bubble cycle; halt parks
// the generator until the next such event.
//
// Optional feature macro: PC_RAS_EN -- adds a circular return-address stack
// of RAS_DEPTH entries (push = call, pop = return redirect). Without it the
// RAS inputs are ignored and o_ras_empty is tied to 1.
//
// Ports:
//   clk             clock, all state updates on posedge
//   reset_n         synchronous active-low reset
//   io_fetch        fetch bus (pc_out, pc_valid, pc_seq out; pc_ready in)
//   i_halt          stop issuing PCs after the current handshake
//   i_redirect      load i_redirect_pc
//   i_redirect_pc   redirect target
//   i_trap          load TRAP_VEC
//   i_ras_push      push i_ras_push_pc onto the RAS
//   i_ras_push_pc   return address to push
//   i_ras_pop       redirect to the RAS top entry
//   o_misalign      1-cycle pulse: the loaded target had low bits set
//   o_ras_empty     RAS holds no entries
// ---------------------------------------------------------------------------
module pc_gen #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     INCR      = 4,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h100,
    parameter int unsigned     RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    pc_gen_if.master        io_fetch,
    input  logic            i_halt,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_trap,
    input  logic            i_ras_push,
    input  logic [XLEN-1:0] i_ras_push_pc,
    input  logic            i_ras_pop,
    output logic            o_misalign,
    output logic            o_ras_empty
);
    // Low bits that must be zero in any PC (INCR is a power of two).
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INCR - 1);

    typedef enum logic [1:0] {
        ST_BUBBLE,
        ST_RUN,
        ST_HALTED
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_pc_valid;
    logic            r_misalign;

    wire  [XLEN-1:0] w_pc_seq    = r_pc + XLEN'(INCR);
    wire             w_handshake = r_pc_valid & io_fetch.pc_ready;

    logic            w_ras_hit;
    logic [XLEN-1:0] w_ras_target;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]  r_ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] r_ras_top;    // index of the most recent entry
    logic [CNT_W-1:0] r_ras_cnt;

    assign w_ras_hit    = i_ras_pop & (r_ras_cnt != '0);
    assign w_ras_target = r_ras_mem[r_ras_top];
    assign o_ras_empty  = (r_ras_cnt == '0);

    // NOTE: storage arrays carry no reset; the count alone decides which
    // entries are meaningful, so clearing the data would only cost logic.
    always_ff @(posedge clk) begin
        if (reset_n && i_ras_push) begin
            // Push with a successful pop replaces the top that is being returned to.
            if (w_ras_hit)
                r_ras_mem[r_ras_top] <= i_ras_push_pc;
            else
                r_ras_mem[r_ras_top + PTR_W'(1)] <= i_ras_push_pc;
        end
    end

    // The stack updates even when trap/redirect wins the PC priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ras_top <= '0;
            r_ras_cnt <= '0;
        end else if (i_ras_push && !w_ras_hit) begin
            // A full stack wraps onto its oldest entry; the count saturates.
            r_ras_top <= r_ras_top + PTR_W'(1);
            if (r_ras_cnt != CNT_W'(RAS_DEPTH))
                r_ras_cnt <= r_ras_cnt + CNT_W'(1);
        end else if (w_ras_hit && !i_ras_push) begin
            r_ras_top <= r_ras_top - PTR_W'(1);
            r_ras_cnt <= r_ras_cnt - CNT_W'(1);
        end
    end
`else
    assign w_ras_hit    = 1'b0;
    assign w_ras_target = '0;
    assign o_ras_empty  = 1'b1;

    wire w_unused_ras = &{1'b0, i_ras_push, i_ras_pop, i_ras_push_pc, (RAS_DEPTH >= 2)};
`endif

    // Next-target selection: trap > redirect > RAS return.
    logic            w_load;
    logic [XLEN-1:0] w_target;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_load   = 1'b1;
        w_target = TRAP_VEC;
        if (i_trap)
            w_target = TRAP_VEC;
        else if (i_redirect)
            w_target = i_redirect_pc;
        else if (w_ras_hit)
            w_target = w_ras_target;
        else
            w_load = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pc       <= RESET_VEC;
            r_pc_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_state    <= ST_BUBBLE;
        end else begin
            r_misalign <= w_load & (|(w_target & ALIGN_MASK));
            if (w_load) begin
                // Any outstanding PC is dropped; the target appears after one bubble.
                r_pc       <= w_target & ~ALIGN_MASK;
                r_pc_valid <= 1'b0;
                r_state    <= ST_BUBBLE;
            end else begin
                case (r_state)
                    ST_BUBBLE: begin
                        r_state    <= i_halt ? ST_HALTED : ST_RUN;
                        r_pc_valid <= !i_halt;
                    end
                    ST_RUN: begin
                        if (w_handshake)
                            r_pc <= w_pc_seq;
                        // In RUN pc_valid is 1, so either the PC was taken or
                        // it stalled; both park here.
                        if (i_halt && (w_handshake || !io_fetch.pc_ready)) begin
                            r_state    <= ST_HALTED;
                            r_pc_valid <= 1'b0;
                        end
                    end
                    ST_HALTED: begin
                        r_pc_valid <= 1'b0;
                    end
                    default: begin
                        r_state    <= ST_BUBBLE;
                        r_pc_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io_fetch.pc_out   = r_pc;
    assign io_fetch.pc_valid = r_pc_valid;
    assign io_fetch.pc_seq   = w_pc_seq;
    assign o_misalign        = r_misalign;
endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- directed bench for pc_gen (XLEN=32, INCR=4, RESET_VEC=0,
// TRAP_VEC=0x100, RAS_DEPTH=4). A behavioural model tracks the expected
// fetch PC from the event rules; a negedge process compares every cycle,
// and hand-computed literal checks pin the model at key points.
// ---------------------------------------------------------------------------
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        halt, redirect, trap, ras_push, ras_pop;
    logic [31:0] redirect_pc, ras_push_pc;
    logic        misalign, ras_empty;

    int n_checks = 0;
    int n_errors = 0;

    pc_gen_if #(.XLEN(32)) fetch_if ();

    pc_gen dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .io_fetch      (fetch_if),
        .i_halt        (halt),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_trap        (trap),
        .i_ras_push    (ras_push),
        .i_ras_push_pc (ras_push_pc),
        .i_ras_pop     (ras_pop),
        .o_misalign    (misalign),
        .o_ras_empty   (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_init = 1'b0;
    logic [31:0] m_pc;
    bit          m_valid, m_bubble, m_mis;
    logic [31:0] m_ras[$];

    always @(posedge clk) begin
        logic [31:0] t, t_ras;
        bit ld, hit;
        if (!reset_n) begin
            m_init = 1'b1; m_pc = 32'h0; m_valid = 1'b0; m_bubble = 1'b1; m_mis = 1'b0;
            m_ras.delete();
        end else begin
            hit = 1'b0; t = 32'h0; t_ras = 32'h0;
`ifdef PC_RAS_EN
            if (ras_pop && m_ras.size() > 0) begin
                hit = 1'b1;
                if (ras_push) begin
                    t_ras = m_ras[m_ras.size()-1];
                    m_ras[m_ras.size()-1] = ras_push_pc;
                end else begin
                    t_ras = m_ras.pop_back();
                end
            end else if (ras_push) begin
                m_ras.push_back(ras_push_pc);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
`endif
            ld = 1'b1;
            if (trap)          t = 32'h100;
            else if (redirect) t = redirect_pc;
            else if (hit)      t = t_ras;
            else               ld = 1'b0;
            if (ld) begin
                m_pc = t & ~32'h3; m_mis = (t[1:0] != 2'b0); m_valid = 1'b0; m_bubble = 1'b1;
            end else begin
                m_mis = 1'b0;
                if (m_valid) begin
                    if (fetch_if.pc_ready) m_pc = m_pc + 32'd4;
                    if (halt) m_valid = 1'b0;
                end else if (m_bubble) begin
                    m_bubble = 1'b0;
                    m_valid = !halt;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_init) begin
            check("cyc pc_valid", {31'b0, fetch_if.pc_valid}, {31'b0, m_valid});
            check("cyc pc_out", fetch_if.pc_out, m_pc);
            check("cyc pc_seq", fetch_if.pc_seq, m_pc + 32'd4);
            check("cyc misalign", {31'b0, misalign}, {31'b0, m_mis});
            check("cyc ras_empty", {31'b0, ras_empty}, {31'b0, (m_ras.size() == 0)});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pc(input string name, input logic [31:0] pc, input logic vld);
        check({name, " pc"}, fetch_if.pc_out, pc);
        check({name, " valid"}, {31'b0, fetch_if.pc_valid}, {31'b0, vld});
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        logic [31:0] pops [4];
        logic [31:0] pc_before;
        pops = '{32'h50, 32'h40, 32'h30, 32'h20};

        reset_n = 1'b0; halt = 1'b0; redirect = 1'b0; trap = 1'b0;
        ras_push = 1'b0; ras_pop = 1'b0; redirect_pc = 32'h0; ras_push_pc = 32'h0;
        fetch_if.pc_ready = 1'b1;
        cyc(2);
        reset_n = 1'b1;

        // 1: reset then free run
        expect_pc("t1 reset", 32'h0, 1'b0);
        check("t1 reset misalign", {31'b0, misalign}, 32'h0);
        cyc(1); expect_pc("t1 c1", 32'h0, 1'b1);
        cyc(1); expect_pc("t1 c2", 32'h4, 1'b1);
        cyc(1); expect_pc("t1 c3", 32'h8, 1'b1);

        // 2: stall at 0x8 for 3 cycles
        fetch_if.pc_ready = 1'b0;
        cyc(3); expect_pc("t2 stall", 32'h8, 1'b1);
        fetch_if.pc_ready = 1'b1;
        cyc(1); expect_pc("t2 resume", 32'hC, 1'b1);

        // 3: trap beats redirect
        trap = 1'b1; redirect = 1'b1; redirect_pc = 32'h40;
        cyc(1); trap = 1'b0; redirect = 1'b0;
        expect_pc("t3 bubble", 32'h100, 1'b0);
        cyc(1); expect_pc("t3 target", 32'h100, 1'b1);
        cyc(1); expect_pc("t3 seq", 32'h104, 1'b1);

        // 4: misaligned redirect, then wrap
        redirect = 1'b1; redirect_pc = 32'h43;
        cyc(1); redirect = 1'b0;
        expect_pc("t4 bubble", 32'h40, 1'b0);
        check("t4 misalign pulse", {31'b0, misalign}, 32'h1);
        cyc(1); expect_pc("t4 target", 32'h40, 1'b1);
        check("t4 misalign end", {31'b0, misalign}, 32'h0);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc(1); redirect = 1'b0;
        cyc(1); expect_pc("t4 top", 32'hFFFF_FFFC, 1'b1);
        check("t4 pc_seq wrap", fetch_if.pc_seq, 32'h0);
        cyc(1); expect_pc("t4 wrapped", 32'h0, 1'b1);

        // 5: halt with a handshake, then redirect out of HALTED
        halt = 1'b1;
        cyc(1); halt = 1'b0;
        expect_pc("t5 halted", 32'h4, 1'b0);
        cyc(2); expect_pc("t5 held", 32'h4, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc(1); redirect = 1'b0;
        expect_pc("t5 bubble", 32'h200, 1'b0);
        cyc(1); expect_pc("t5 target", 32'h200, 1'b1);
        cyc(1); expect_pc("t5 seq", 32'h204, 1'b1);

`ifdef PC_RAS_EN
        // 6: five pushes into a 4-deep stack, five pops
        for (int i = 1; i <= 5; i++) begin
            ras_push = 1'b1; ras_push_pc = 32'(i * 16);
            cyc(1);
        end
        ras_push = 1'b0;
        check("t6 not empty", {31'b0, ras_empty}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ras_pop = 1'b1;
            cyc(1); ras_pop = 1'b0;
            expect_pc("t6 pop bubble", pops[i], 1'b0);
            cyc(1); expect_pc("t6 pop target", pops[i], 1'b1);
        end
        check("t6 empty", {31'b0, ras_empty}, 32'h1);
        pc_before = fetch_if.pc_out;
        ras_pop = 1'b1;
        cyc(1); ras_pop = 1'b0;
        expect_pc("t6 pop ignored", pc_before + 32'd4, 1'b1);
`else
        // Without the RAS, push/pop are inert and the stack reads empty.
        pc_before = fetch_if.pc_out;
        ras_push = 1'b1; ras_push_pc = 32'h10;
        cyc(1); ras_push = 1'b0; ras_pop = 1'b1;
        cyc(1); ras_pop = 1'b0;
        expect_pc("t6 ras inert", pc_before + 32'd8, 1'b1);
        check("t6 ras_empty tied", {31'b0, ras_empty}, 32'h1);
`endif

        // Reset overrides a simultaneous trap and redirect.
        reset_n = 1'b0; trap = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
        cyc(1); reset_n = 1'b1; trap = 1'b0; redirect = 1'b0;
        expect_pc("rst override", 32'h0, 1'b0);
        cyc(2); expect_pc("rst rerun", 32'h4, 1'b1);

        cyc(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
